// File: rtl/pos_pkg.sv
// Shared types and constants for the parallel output serializer.
// Holds the narrowed sample and pair types plus the output phase encoding.
package pos_pkg;

  localparam int DATA_IN_W_DEF  = 64;
  localparam int DATA_OUT_W_DEF = 32;

  typedef logic signed [31:0] sample_t;

  typedef struct packed {
    sample_t even;
    sample_t odd;
  } pair_t;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    SEND_EVEN = 2'd1,
    SEND_ODD  = 2'd2
  } phase_e;

  localparam sample_t SAMPLE_MAX = 32'sh7FFF_FFFF;
  localparam sample_t SAMPLE_MIN = 32'sh8000_0000;

endpackage

// File: rtl/pos_pair_fifo.sv
// Synchronous FIFO of sample pairs with simultaneous push/pop.
// Exposes the head entry and the entry behind it for look-ahead loading.
module pos_pair_fifo
  import pos_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  pair_t                    wdata,
  output pair_t                    head,
  output pair_t                    head_next,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  pair_t            mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr + AW'(1)];
  assign level     = count;

endmodule

// File: rtl/parallel_output_serializer.sv
// Serializes L=2 FIR output pairs into one 32-bit sample per cycle (even, then odd).
// Define PARALLEL_OUTPUT_SERIALIZER_SAT_EN for saturating narrowing and the sat_event port.
module parallel_output_serializer
  import pos_pkg::*;
#(
  parameter int DATA_IN_W  = DATA_IN_W_DEF,
  parameter int DATA_OUT_W = DATA_OUT_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_IN_W-1:0]          y_in0,
  input  logic [DATA_IN_W-1:0]          y_in1,
  output logic [DATA_OUT_W-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
`ifdef PARALLEL_OUTPUT_SERIALIZER_SAT_EN
  output logic                          sat_event,
`endif
  output logic                          overflow
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

`ifdef PARALLEL_OUTPUT_SERIALIZER_SAT_EN
  localparam logic signed [DATA_IN_W-1:0] SAT_MAX =
    {{(DATA_IN_W-DATA_OUT_W+1){1'b0}}, {(DATA_OUT_W-1){1'b1}}};
  localparam logic signed [DATA_IN_W-1:0] SAT_MIN =
    {{(DATA_IN_W-DATA_OUT_W+1){1'b1}}, {(DATA_OUT_W-1){1'b0}}};

  function automatic logic clipped(input logic signed [DATA_IN_W-1:0] x);
    return (x > SAT_MAX) || (x < SAT_MIN);
  endfunction

  function automatic sample_t narrow(input logic signed [DATA_IN_W-1:0] x);
    if (x > SAT_MAX)      return SAMPLE_MAX;
    else if (x < SAT_MIN) return SAMPLE_MIN;
    else                  return sample_t'(x[DATA_OUT_W-1:0]);
  endfunction
`else
  function automatic sample_t narrow(input logic signed [DATA_IN_W-1:0] x);
    return sample_t'(x[DATA_OUT_W-1:0]);
  endfunction
`endif

  phase_e          phase_q, phase_d;
  sample_t         data_q, data_d;
  logic            valid_q, valid_d;
  logic            overflow_q;
  pair_t           wr_pair;
  pair_t           head;
  pair_t           head_next;
  logic            fifo_full;
  logic            fifo_empty;
  logic [LW-1:0]   level;
  logic            push;
  logic            pop;

  assign wr_pair.even = narrow(y_in0);
  assign wr_pair.odd  = narrow(y_in1);

  // A pair may enter a full FIFO only when the head leaves in the same cycle.
  assign pop  = (phase_q == SEND_ODD) && out_ready && !fifo_empty;
  assign push = in_valid && (!fifo_full || pop);

  pos_pair_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .wdata     (wr_pair),
    .head      (head),
    .head_next (head_next),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  // Next sample is chosen ahead so out_data can be a plain register.
  always_comb begin
    phase_d = phase_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (phase_q)
      EMPTY: begin
        if (push) begin
          phase_d = SEND_EVEN;
          data_d  = wr_pair.even;
          valid_d = 1'b1;
        end
      end
      SEND_EVEN: begin
        if (out_ready) begin
          phase_d = SEND_ODD;
          data_d  = head.odd;
        end
      end
      SEND_ODD: begin
        if (pop) begin
          if (level > LW'(1)) begin
            phase_d = SEND_EVEN;
            data_d  = head_next.even;
          end else if (push) begin
            phase_d = SEND_EVEN;
            data_d  = wr_pair.even;
          end else begin
            phase_d = EMPTY;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        phase_d = EMPTY;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q    <= EMPTY;
      data_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_q | (in_valid & ~push);
    end
  end

`ifdef PARALLEL_OUTPUT_SERIALIZER_SAT_EN
  logic sat_q;

  always_ff @(posedge clk) begin
    if (!rst) sat_q <= 1'b0;
    else      sat_q <= push & (clipped(y_in0) | clipped(y_in1));
  end

  assign sat_event = sat_q;
`endif

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign fifo_level = level;
  assign overflow   = overflow_q;

endmodule
